// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between NREQ writeback
//   sources. A round-robin arbiter picks one valid requester per cycle and the
//   winner is registered onto wena/rw/wdata. The module also keeps a busy bit
//   per register so that decode can detect read-after-write hazards.
//
// Handshake: a requester transfers in a cycle where req_valid[i] & req_ready[i]
//   are both high. req_ready is one-hot, never asserts without req_valid, and
//   requesters hold addr/data stable and valid high until they are granted.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester valid in, one-hot grant out
//   req_addr/req_data     packed per-requester dest register and write data
//   rsv_en/rsv_addr       issue stage reserves a destination register
//   rsv_ready             reservation accepted this cycle
//   ra, rb                decode read addresses
//   hazard_a/hazard_b     ra/rb have a pending write
//   wena, rw, wdata       registered register-file write port
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic               rsv_ready,
  input  logic [AW-1:0]      ra,
  input  logic [AW-1:0]      rb,
  output logic               hazard_a,
  output logic               hazard_b,
  output logic               wena,
  output logic [AW-1:0]      rw,
  output logic [DW-1:0]      wdata
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2**AW;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   ptr_next;
  logic            any_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] busy;

  // Scan from the highest offset down so the last match written is the
  // requester closest to ptr, which is the round-robin winner.
  always_comb begin
    winner   = ptr;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(ptr) + k) % NREQ);
      if (req_valid[scan_idx]) winner = scan_idx;
    end
  end

  assign any_valid = |req_valid;
  assign req_ready = any_valid ? (NREQ'(1) << winner) : '0;
  assign win_addr  = req_addr[int'(winner)*AW +: AW];
  assign win_data  = req_data[int'(winner)*DW +: DW];
  assign ptr_next  = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);

  // busy[0] is never set, so register 0 is always accepted and never hazards.
  assign rsv_ready = rsv_en & ((rsv_addr == '0) | ~busy[rsv_addr]);
  assign hazard_a  = busy[ra];
  assign hazard_b  = busy[rb];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      wena  <= 1'b0;
      rw    <= '0;
      wdata <= '0;
      busy  <= '0;
    end else begin
      if (any_valid) ptr <= ptr_next;

      // A grant to register 0 is consumed but produces no write.
      wena <= any_valid && (win_addr != '0);
      if (any_valid && (win_addr != '0)) begin
        rw    <= win_addr;
        wdata <= win_data;
      end

      // Clear first, then set: a reservation landing on the edge that
      // retires a write to the same register stays pending.
      if (wena) busy[rw] <= 1'b0;
      if (rsv_ready && (rsv_addr != '0)) busy[rsv_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NV   = 15;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic               rsv_ready;
  logic [AW-1:0]      ra, rb;
  logic               hazard_a, hazard_b;
  logic               wena;
  logic [AW-1:0]      rw;
  logic [DW-1:0]      wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .ra(ra), .rb(rb), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wena(wena), .rw(rw), .wdata(wdata)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]    valid;
    logic [AW-1:0] a0, a1, a2;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr, ra, rb;
    logic [2:0]    exp_ready;
    logic          exp_rsv, exp_ha, exp_hb, exp_wena;
    logic [AW-1:0] exp_rw;
  } vec_t;

  vec_t vecs[NV];

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_wdata;

  function automatic vec_t mk(input logic [2:0] valid, input int a0, a1, a2,
                              input logic re, input int radr, input int xa, xb,
                              input logic [2:0] er, input logic ers, eha, ehb, ew,
                              input int erw);
    vec_t t;
    t.valid = valid; t.a0 = AW'(a0); t.a1 = AW'(a1); t.a2 = AW'(a2);
    t.rsv_en = re; t.rsv_addr = AW'(radr); t.ra = AW'(xa); t.rb = AW'(xb);
    t.exp_ready = er; t.exp_rsv = ers; t.exp_ha = eha; t.exp_hb = ehb;
    t.exp_wena = ew; t.exp_rw = AW'(erw);
    return t;
  endfunction

  function automatic logic [DW-1:0] dval(input int i, input int v);
    return 32'hC0DE_0000 | DW'(i << 8) | DW'(v);
  endfunction

  function automatic int oh_idx(input logic [2:0] oh);
    return oh[0] ? 0 : (oh[1] ? 1 : 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] valid, input logic [AW-1:0] a0, a1, a2,
                           input int v);
    req_valid = valid;
    req_addr  = {a2, a1, a0};
    req_data  = {dval(2, v), dval(1, v), dval(0, v)};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  // ---------------- main test ----------------
  initial begin
    //                valid  a0 a1 a2 rsv  adr ra rb  ready   rsv  ha   hb   wena rw
    vecs[0]  = mk(3'b000, 1, 2, 3, 1'b0, 0, 0, 0, 3'b000, 1'b0,1'b0,1'b0,1'b0, 0);
    vecs[1]  = mk(3'b111, 1, 2, 3, 1'b0, 0, 1, 2, 3'b001, 1'b0,1'b0,1'b0,1'b1, 1);
    vecs[2]  = mk(3'b111, 1, 2, 3, 1'b0, 0, 1, 2, 3'b010, 1'b0,1'b0,1'b0,1'b1, 2);
    vecs[3]  = mk(3'b111, 1, 2, 3, 1'b0, 0, 1, 2, 3'b100, 1'b0,1'b0,1'b0,1'b1, 3);
    vecs[4]  = mk(3'b011, 1, 2, 3, 1'b0, 0, 1, 2, 3'b001, 1'b0,1'b0,1'b0,1'b1, 1);
    vecs[5]  = mk(3'b101, 1, 2, 3, 1'b0, 0, 1, 2, 3'b100, 1'b0,1'b0,1'b0,1'b1, 3);
    vecs[6]  = mk(3'b010, 1, 2, 3, 1'b0, 0, 1, 2, 3'b010, 1'b0,1'b0,1'b0,1'b1, 2);
    vecs[7]  = mk(3'b001, 1, 2, 3, 1'b1, 4, 4, 0, 3'b001, 1'b1,1'b0,1'b0,1'b1, 1);
    vecs[8]  = mk(3'b000, 1, 2, 3, 1'b1, 4, 4, 0, 3'b000, 1'b0,1'b1,1'b0,1'b0, 1);
    vecs[9]  = mk(3'b100, 1, 2, 4, 1'b1, 6, 4, 4, 3'b100, 1'b1,1'b1,1'b1,1'b1, 4);
    vecs[10] = mk(3'b000, 1, 2, 4, 1'b0, 0, 4, 6, 3'b000, 1'b0,1'b1,1'b1,1'b0, 4);
    vecs[11] = mk(3'b001, 0, 2, 4, 1'b1, 4, 4, 6, 3'b001, 1'b1,1'b0,1'b1,1'b0, 4);
    vecs[12] = mk(3'b010, 0, 6, 4, 1'b0, 0, 0, 4, 3'b010, 1'b0,1'b0,1'b1,1'b1, 6);
    vecs[13] = mk(3'b000, 0, 6, 4, 1'b0, 0, 4, 6, 3'b000, 1'b0,1'b1,1'b1,1'b0, 6);
    vecs[14] = mk(3'b000, 0, 6, 4, 1'b0, 0, 4, 6, 3'b000, 1'b0,1'b1,1'b0,1'b0, 6);

    rst = 1'b1; rsv_en = 1'b0; rsv_addr = '0; ra = '0; rb = '0;
    drive_req(3'b000, '0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset wena", 32'(wena), 32'd0);
    chk("reset rw", 32'(rw), 32'd0);
    chk("reset wdata", wdata, 32'd0);
    rst = 1'b0;
    exp_wdata = '0;

    // Table-driven sequence starting from the reset state.
    for (int v = 0; v < NV; v++) begin
      drive_req(vecs[v].valid, vecs[v].a0, vecs[v].a1, vecs[v].a2, v);
      rsv_en = vecs[v].rsv_en; rsv_addr = vecs[v].rsv_addr;
      ra = vecs[v].ra; rb = vecs[v].rb;
      #1;
      chk($sformatf("v%0d req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      chk($sformatf("v%0d rsv_ready", v), 32'(rsv_ready), 32'(vecs[v].exp_rsv));
      chk($sformatf("v%0d hazard_a", v), 32'(hazard_a), 32'(vecs[v].exp_ha));
      chk($sformatf("v%0d hazard_b", v), 32'(hazard_b), 32'(vecs[v].exp_hb));
      if (vecs[v].exp_wena) exp_q.push_back(dval(oh_idx(vecs[v].exp_ready), v));
      tick();
      if (exp_q.size() > 0) exp_wdata = exp_q.pop_front();
      chk($sformatf("v%0d wena", v), 32'(wena), 32'(vecs[v].exp_wena));
      if (vecs[v].exp_wena || vecs[v].exp_ready == 3'b000) begin
        chk($sformatf("v%0d rw", v), 32'(rw), 32'(vecs[v].exp_rw));
        chk($sformatf("v%0d wdata", v), wdata, exp_wdata);
      end
    end

    // Reset arriving while a handshake is in flight discards it.
    drive_req(3'b001, 5'd5, 5'd0, 5'd0, 30);
    rsv_en = 1'b1; rsv_addr = 5'd5; ra = 5'd5; rb = 5'd4;
    #1;
    chk("rst_mid ready before", 32'(req_ready), 32'b001);
    rst = 1'b1;
    tick();
    chk("rst_mid wena", 32'(wena), 32'd0);
    chk("rst_mid rw", 32'(rw), 32'd0);
    chk("rst_mid wdata", wdata, 32'd0);
    rst = 1'b0; rsv_en = 1'b0;
    drive_req(3'b111, 5'd1, 5'd2, 5'd3, 30);
    #1;
    chk("rst_mid hazard_a", 32'(hazard_a), 32'd0);
    chk("rst_mid hazard_b", 32'(hazard_b), 32'd0);
    chk("rst_mid ptr", 32'(req_ready), 32'b001);
    drive_req(3'b000, '0, '0, '0, 30);
    tick();

    // Round-robin with all requesters held valid for six cycles.
    drive_req(3'b111, 5'd10, 5'd11, 5'd12, 20);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr%0d grant", c), 32'(req_ready), 32'(3'b001 << (c % 3)));
      tick();
      chk($sformatf("rr%0d wena", c), 32'(wena), 32'd1);
      chk($sformatf("rr%0d rw", c), 32'(rw), 32'(10 + c % 3));
      chk($sformatf("rr%0d wdata", c), wdata, dval(c % 3, 20));
    end
    drive_req(3'b000, '0, '0, '0, 20);
    tick();
    chk("rr idle wena", 32'(wena), 32'd0);

    // A second reservation of a busy register is refused.
    rsv_en = 1'b1; rsv_addr = 5'd9; ra = 5'd9; rb = 5'd0;
    #1;
    chk("waw first rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    chk("waw second rsv_ready", 32'(rsv_ready), 32'd0);
    chk("waw hazard_a", 32'(hazard_a), 32'd1);
    tick();
    rsv_en = 1'b0;
    #1;
    chk("waw busy held", 32'(hazard_a), 32'd1);

    // Retire the write to 9, then write 9 again while reserving it on the
    // same edge that retires that write.
    drive_req(3'b001, 5'd9, 5'd0, 5'd0, 40);
    tick();
    drive_req(3'b000, '0, '0, '0, 40);
    chk("sc wena", 32'(wena), 32'd1);
    chk("sc rw", 32'(rw), 32'd9);
    chk("sc hazard during wena", 32'(hazard_a), 32'd1);
    tick();
    chk("sc hazard cleared", 32'(hazard_a), 32'd0);
    drive_req(3'b001, 5'd9, 5'd0, 5'd0, 41);
    tick();
    drive_req(3'b000, '0, '0, '0, 41);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    chk("sc wena again", 32'(wena), 32'd1);
    chk("sc rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_en = 1'b0;
    #1;
    chk("sc set wins", 32'(hazard_a), 32'd1);

    // Register 0 write is granted but dropped.
    drive_req(3'b100, 5'd0, 5'd0, 5'd0, 50);
    req_data[2*DW +: DW] = 32'h0000_1234;
    ra = 5'd0;
    #1;
    chk("r0 ready", 32'(req_ready), 32'b100);
    chk("r0 hazard_a", 32'(hazard_a), 32'd0);
    tick();
    drive_req(3'b000, '0, '0, '0, 50);
    chk("r0 wena", 32'(wena), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
